conv_seq_controller: RTL and testbench
======================================

Name: conv_seq_controller

Overview:
- Counter-driven sequencer for the single systolic convolution datapath. Replaces a hard-coded per-cycle state list.
- Walks every output pixel of a valid-mode KxK convolution over an IN_W x IN_W input held in a shared address space. It drives the input and filter read addresses, the MAC enable/clear and the result-buffer write.
- After the run it hands control to a button-driven display mode that steps the buffer read address with left/right.

Parameters:
- IN_W, 4: input feature map width and height.
- K, 3: filter width and height; OUT_W = IN_W-K+1 (derived localparam, 2 at defaults).
- ADDR_W, 5: width of the input/filter address bus.
- FILT_BASE, 16: address of filter tap 0.
- IDLE_ADDR, all ones (31): address driven when no read is active.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  level; sampled in IDLE to begin a run
- toggle  in  1  level; 1 = request display mode
- right  in  1  button; rising edge = next buffer entry
- left  in  1  button; rising edge = previous buffer entry
- input_addr  out  ADDR_W  input array read address
- filter_addr  out  ADDR_W  filter array read address
- mac_en  out  1  systolic MAC accumulate enable
- mac_clr  out  1  clears the MAC accumulator
- buf_we  out  1  result buffer write strobe
- buf_wr_addr  out  BA  buffer write index, where BA = $clog2(OUT_W*OUT_W)
- buf_rd_addr  out  BA  buffer read/display index
- busy  out  1  high in MAC and WRITE
- done  out  1  high in DONE and DISPLAY

Behaviour:
- Reset (async, rst=1): state=IDLE, all counters 0, input_addr=filter_addr=IDLE_ADDR, mac_en=mac_clr=buf_we=0, buf_wr_addr=buf_rd_addr=0, busy=done=0.
- All outputs are registered and change on the same edge as the state. The value in a cycle describes that cycle's operation.
- Counters: ox, oy in 0..OUT_W-1; tap in 0..K*K-1 with kx = tap%K and ky = tap/K. Implement these as nested kx/ky counters, not division.
- FSM states are IDLE, MAC, WRITE, DONE and DISPLAY.
- IDLE:
  - Addresses are IDLE_ADDR.
  - If start=1, go to MAC with tap=ox=oy=0.
- MAC: lasts K*K cycles per pixel, with mac_en=1 throughout.
  - input_addr = (oy+ky)*IN_W + (ox+kx).
  - filter_addr = FILT_BASE + K*K-1-tap, i.e. the filter is rotated 180 degrees.
  - tap advances every cycle. At tap=K*K-1, go to WRITE.
- WRITE: one cycle.
  - mac_en=0, buf_we=1, buf_wr_addr = oy*OUT_W+ox, mac_clr=1.
  - Addresses are IDLE_ADDR.
  - Advance ox, then oy. After the last pixel go to DONE, otherwise go to MAC with tap=0.
- Cycle counts: K*K+1 cycles per pixel, so a full run is OUT_W^2*(K*K+1) cycles (40 at defaults).
- DONE: holds.
  - mac_en=1 is held, which keeps the systolic output path live.
  - Addresses are IDLE_ADDR.
  - toggle=1 goes to DISPLAY. DONE never returns to IDLE without rst.
- DISPLAY:
  - mac_en=1.
  - right edge: buf_rd_addr+1, wrapping from OUT_W^2-1 to 0.
  - left edge: buf_rd_addr-1, wrapping from 0 to OUT_W^2-1.
  - Edges on both buttons in the same cycle: no move.
  - toggle=0 returns to DONE; buf_rd_addr is retained.
- start is ignored outside IDLE. toggle, right and left are ignored outside DONE/DISPLAY.
- Edge detection registers the previous button level. A held button moves the address exactly once.
- Reset during MAC or WRITE aborts immediately: no buf_we pulse, and all counters clear.
- No illegal-state lockup: any unencoded state decodes to IDLE.

Optional Feature:
- Macro: CONV_BTN_SYNC_EN.
- With the macro defined: start, toggle, right and left each pass through a 2-flop synchronizer before use. This adds 2 cycles of latency to start→MAC and to button→buf_rd_addr change. The synchronizer flops reset to 0.
- Without it: inputs are used directly (edge-detect flop only), and start→MAC takes 1 cycle.

Decomposition:
- Package conv_ctrl_pkg holds:
  - the state enum (IDLE, MAC, WRITE, DONE, DISPLAY);
  - the IDLE_ADDR constant;
  - default IN_W/K/FILT_BASE;
  - helper function clog2-based BA.
- Sub-module btn_edge: the optional sync chain plus rising-edge pulse generator. It is instantiated for right and left, and for start/toggle as sync-only.

Test Plan:
- Full run. Stimulus: reset, then start=1 for 1 cycle at defaults. Required:
  - First MAC: input_addr 0,1,2,4,5,6,8,9,10 and filter_addr 24..16.
  - Then WRITE with buf_we=1, buf_wr_addr=0, mac_clr=1.
  - Pixel 3 uses input_addr starting at 5 and ending at 15.
  - done=1 exactly 40 cycles after MAC entry.
- start held high through the run: no restart. start pulses during MAC: counters unaffected.
- DISPLAY navigation: toggle=1 in DONE, then right edges ×5 gives buf_rd_addr 1,2,3,0,1. A left edge from 0 gives 3. Simultaneous left+right gives no change. A held right for 10 cycles gives one step.
- Reset mid-run: rst asserted during WRITE of pixel 1. Outputs go to reset values asynchronously with no buf_we. A new start repeats pixel 0 addresses.
- toggle=1 during MAC: ignored, and the run completes with normal counts. toggle=0 in DISPLAY returns to DONE with buf_rd_addr kept.
- CONV_BTN_SYNC_EN defined: start→first MAC address and right→buf_rd_addr change each take 2 cycles longer than without it.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// Shared types and defaults for the convolution sequencer.
// Build option: CONV_BTN_SYNC_EN adds 2-flop input synchronizers in btn_edge.
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MAC     = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_DISPLAY = 3'd4
    } conv_state_t;

    localparam int DEF_IN_W      = 4;
    localparam int DEF_K         = 3;
    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_FILT_BASE = 16;
    localparam logic [DEF_ADDR_W-1:0] DEF_IDLE_ADDR = {DEF_ADDR_W{1'b1}};

    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    // Width of a buffer index for an out_w x out_w result tile.
    function automatic int ba_width(input int out_w);
        return clog2_min1(out_w * out_w);
    endfunction

endpackage

// File: rtl/conv_seq_controller_btn_edge.sv
// Optional 2-flop synchronizer plus rising-edge detector (or plain synced level).
// Build option: CONV_BTN_SYNC_EN enables the synchronizer chain.
module btn_edge #(
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q
);

    logic lvl_s;
    logic prev_r;

`ifdef CONV_BTN_SYNC_EN
    logic sync1_r;
    logic sync2_r;

    // two-flop synchronizer for the asynchronous switch/button level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    assign lvl_s = sync2_r;
`else
    assign lvl_s = din;
`endif

    // previous level, so a held button yields a single pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= lvl_s;
        end
    end

    assign q = EDGE_EN ? (lvl_s & ~prev_r) : lvl_s;

endmodule

// File: rtl/conv_seq_controller.sv
// Counter-driven sequencer for the systolic KxK valid-mode convolution datapath.
// Build option: CONV_BTN_SYNC_EN synchronizes start/toggle/right/left (see btn_edge).
module conv_seq_controller
    import conv_ctrl_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int K         = DEF_K,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int FILT_BASE = DEF_FILT_BASE,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = {ADDR_W{1'b1}},
    localparam int OUT_W    = IN_W - K + 1,
    localparam int BA       = ba_width(OUT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              toggle,
    input  logic              right,
    input  logic              left,
    output logic [ADDR_W-1:0] input_addr,
    output logic [ADDR_W-1:0] filter_addr,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              buf_we,
    output logic [BA-1:0]     buf_wr_addr,
    output logic [BA-1:0]     buf_rd_addr,
    output logic              busy,
    output logic              done
);

    localparam int KW   = clog2_min1(K);
    localparam int OW   = clog2_min1(OUT_W);
    localparam int NPIX = OUT_W * OUT_W;

    logic start_s;
    logic toggle_s;
    logic right_s;
    logic left_s;

    btn_edge #(.EDGE_EN(1'b0)) u_start  (.clk(clk), .rst(rst), .din(start),  .q(start_s));
    btn_edge #(.EDGE_EN(1'b0)) u_toggle (.clk(clk), .rst(rst), .din(toggle), .q(toggle_s));
    btn_edge #(.EDGE_EN(1'b1)) u_right  (.clk(clk), .rst(rst), .din(right),  .q(right_s));
    btn_edge #(.EDGE_EN(1'b1)) u_left   (.clk(clk), .rst(rst), .din(left),   .q(left_s));

    conv_state_t state_r;
    conv_state_t state_n;
    logic [KW-1:0] kx_r;
    logic [KW-1:0] kx_n;
    logic [KW-1:0] ky_r;
    logic [KW-1:0] ky_n;
    logic [OW-1:0] ox_r;
    logic [OW-1:0] ox_n;
    logic [OW-1:0] oy_r;
    logic [OW-1:0] oy_n;
    logic [BA-1:0] rd_n;

    logic [ADDR_W-1:0] input_addr_n;
    logic [ADDR_W-1:0] filter_addr_n;
    logic              mac_en_n;
    logic              mac_clr_n;
    logic              buf_we_n;
    logic [BA-1:0]     buf_wr_addr_n;
    logic              busy_n;
    logic              done_n;

    // next state, counter advance and display navigation
    always_comb begin
        state_n = state_r;
        kx_n    = kx_r;
        ky_n    = ky_r;
        ox_n    = ox_r;
        oy_n    = oy_r;
        rd_n    = buf_rd_addr;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_n = ST_MAC;
                    kx_n    = {KW{1'b0}};
                    ky_n    = {KW{1'b0}};
                    ox_n    = {OW{1'b0}};
                    oy_n    = {OW{1'b0}};
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (kx_r == KW'(K - 1)) begin
                    kx_n = {KW{1'b0}};
                    if (ky_r == KW'(K - 1)) begin
                        ky_n    = {KW{1'b0}};
                        state_n = ST_WRITE;
                    end else begin
                        ky_n = ky_r + {{(KW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    kx_n = kx_r + {{(KW-1){1'b0}}, 1'b1};
                end
            end
            ST_WRITE: begin
                state_n = ST_MAC;
                if (ox_r == OW'(OUT_W - 1)) begin
                    ox_n = {OW{1'b0}};
                    if (oy_r == OW'(OUT_W - 1)) begin
                        oy_n    = {OW{1'b0}};
                        state_n = ST_DONE;
                    end else begin
                        oy_n = oy_r + {{(OW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    ox_n = ox_r + {{(OW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (toggle_s) begin
                    state_n = ST_DISPLAY;
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_DISPLAY: begin
                if (!toggle_s) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_DISPLAY;
                end
                // simultaneous edges cancel
                if (right_s && !left_s) begin
                    if (buf_rd_addr == BA'(NPIX - 1)) begin
                        rd_n = {BA{1'b0}};
                    end else begin
                        rd_n = buf_rd_addr + {{(BA-1){1'b0}}, 1'b1};
                    end
                end else if (left_s && !right_s) begin
                    if (buf_rd_addr == {BA{1'b0}}) begin
                        rd_n = BA'(NPIX - 1);
                    end else begin
                        rd_n = buf_rd_addr - {{(BA-1){1'b0}}, 1'b1};
                    end
                end else begin
                    rd_n = buf_rd_addr;
                end
            end
            default: begin
                state_n = ST_IDLE;
                kx_n    = {KW{1'b0}};
                ky_n    = {KW{1'b0}};
                ox_n    = {OW{1'b0}};
                oy_n    = {OW{1'b0}};
            end
        endcase
    end

    // outputs decoded from the upcoming state so they register alongside it
    always_comb begin
        input_addr_n  = IDLE_ADDR;
        filter_addr_n = IDLE_ADDR;
        mac_en_n      = 1'b0;
        mac_clr_n     = 1'b0;
        buf_we_n      = 1'b0;
        buf_wr_addr_n = buf_wr_addr;
        busy_n        = 1'b0;
        done_n        = 1'b0;
        case (state_n)
            ST_MAC: begin
                input_addr_n  = ADDR_W'((32'(oy_n) + 32'(ky_n)) * IN_W + 32'(ox_n) + 32'(kx_n));
                // filter taps walked in reverse: 180-degree rotation
                filter_addr_n = ADDR_W'(FILT_BASE + K * K - 1 - (32'(ky_n) * K + 32'(kx_n)));
                mac_en_n      = 1'b1;
                busy_n        = 1'b1;
            end
            ST_WRITE: begin
                mac_clr_n     = 1'b1;
                buf_we_n      = 1'b1;
                buf_wr_addr_n = BA'(32'(oy_n) * OUT_W + 32'(ox_n));
                busy_n        = 1'b1;
            end
            ST_DONE, ST_DISPLAY: begin
                mac_en_n = 1'b1;
                done_n   = 1'b1;
            end
            default: begin
                mac_en_n = 1'b0;
            end
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            kx_r        <= {KW{1'b0}};
            ky_r        <= {KW{1'b0}};
            ox_r        <= {OW{1'b0}};
            oy_r        <= {OW{1'b0}};
            input_addr  <= IDLE_ADDR;
            filter_addr <= IDLE_ADDR;
            mac_en      <= 1'b0;
            mac_clr     <= 1'b0;
            buf_we      <= 1'b0;
            buf_wr_addr <= {BA{1'b0}};
            buf_rd_addr <= {BA{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= state_n;
            kx_r        <= kx_n;
            ky_r        <= ky_n;
            ox_r        <= ox_n;
            oy_r        <= oy_n;
            input_addr  <= input_addr_n;
            filter_addr <= filter_addr_n;
            mac_en      <= mac_en_n;
            mac_clr     <= mac_clr_n;
            buf_we      <= buf_we_n;
            buf_wr_addr <= buf_wr_addr_n;
            buf_rd_addr <= rd_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_conv_seq_controller.sv
// Self-checking bench for conv_seq_controller at default parameters.
module tb_conv_seq_controller;

    localparam int IN_W = 4;
    localparam int K = 3;
    localparam int OUT_W = 2;
    localparam int FILT_BASE = 16;
    localparam logic [4:0] IDLE = 5'd31;
`ifdef CONV_BTN_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic toggle = 1'b0;
    logic right = 1'b0;
    logic left = 1'b0;
    logic [4:0] input_addr;
    logic [4:0] filter_addr;
    logic mac_en;
    logic mac_clr;
    logic buf_we;
    logic [1:0] buf_wr_addr;
    logic [1:0] buf_rd_addr;
    logic busy;
    logic done;

    conv_seq_controller dut (
        .clk(clk), .rst(rst), .start(start), .toggle(toggle), .right(right), .left(left),
        .input_addr(input_addr), .filter_addr(filter_addr), .mac_en(mac_en), .mac_clr(mac_clr),
        .buf_we(buf_we), .buf_wr_addr(buf_wr_addr), .buf_rd_addr(buf_rd_addr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;
    logic [16:0] exp_q[$];
    int rd_m = 0;

    typedef struct {
        bit r;
        bit l;
        logic [1:0] exp_rd;
    } nav_vec_t;
    nav_vec_t nav_tbl[11];

    function automatic logic [16:0] pack(input logic [4:0] ia, input logic [4:0] fa,
                                         input logic me, input logic mc, input logic we,
                                         input logic [1:0] wa, input logic bz, input logic dn);
        return {ia, fa, me, mc, we, wa, bz, dn};
    endfunction

    function automatic logic [16:0] outs();
        return pack(input_addr, filter_addr, mac_en, mac_clr, buf_we, buf_wr_addr, busy, done);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected per-cycle trace of a whole run, computed pixel by pixel from the addressing rules.
    function automatic void build_trace();
        logic [1:0] last_wr;
        int t;
        exp_q.delete();
        last_wr = 2'd0;
        for (int oy = 0; oy < OUT_W; oy++) begin
            for (int ox = 0; ox < OUT_W; ox++) begin
                for (t = 0; t < K * K; t++) begin
                    exp_q.push_back(pack(5'((oy + t / K) * IN_W + ox + t % K),
                                         5'(FILT_BASE + K * K - 1 - t),
                                         1'b1, 1'b0, 1'b0, last_wr, 1'b1, 1'b0));
                end
                last_wr = 2'(oy * OUT_W + ox);
                exp_q.push_back(pack(IDLE, IDLE, 1'b0, 1'b1, 1'b1, last_wr, 1'b1, 1'b0));
            end
        end
        exp_q.push_back(pack(IDLE, IDLE, 1'b1, 1'b0, 1'b0, last_wr, 1'b0, 1'b1));
    endfunction

    // Start a run and compare cycles 0..last against the trace; noise perturbs ignored inputs.
    task automatic do_run(input bit hold_start, input bit noise, input int last);
        build_trace();
        start = 1'b1;
        toggle = 1'b0;
        right = 1'b0;
        left = 1'b0;
        check("idle_before_start", {27'd0, input_addr}, {27'd0, IDLE});
        for (int i = 0; i < SYNC_LAT; i++) begin
            step();
            if (!hold_start) start = 1'b0;
            check("start_latency_idle", {26'd0, busy, input_addr}, {26'd0, 1'b0, IDLE});
        end
        step();
        if (!hold_start) start = 1'b0;
        for (int c = 0; c <= last; c++) begin
            check($sformatf("run_cyc%0d", c), {15'd0, outs()}, {15'd0, exp_q[c]});
            if (c == 0) check("first_in_addr", {27'd0, input_addr}, 32'd0);
            if (c == 0) check("first_filt_addr", {27'd0, filter_addr}, 32'd24);
            if (c == 8) check("last_filt_addr", {27'd0, filter_addr}, 32'd16);
            if (c == 9) check("write0", {28'd0, buf_we, mac_clr, buf_wr_addr}, {28'd0, 4'b1100});
            if (c == 30) check("pix3_first", {27'd0, input_addr}, 32'd5);
            if (c == 38) check("pix3_last", {27'd0, input_addr}, 32'd15);
            if (c == 40) check("done_at_40", {31'd0, done}, 32'd1);
            if (c == last) break;
            if (noise) begin
                if (c < 30) begin
                    toggle = hold_start ? 1'b1 : 1'($urandom % 2);
                    right = 1'($urandom % 2);
                    left = 1'($urandom % 2);
                    if (!hold_start) start = 1'($urandom % 2);
                end else begin
                    toggle = 1'b0;
                    right = 1'b0;
                    left = 1'b0;
                    start = hold_start;
                end
            end
            step();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        bit rq[$];
        bit lq[$];
        bit er, el, pr, pl;
        int n;
        nav_tbl[0] = '{1'b1, 1'b0, 2'd1};
        nav_tbl[1] = '{1'b1, 1'b0, 2'd2};
        nav_tbl[2] = '{1'b1, 1'b0, 2'd3};
        nav_tbl[3] = '{1'b1, 1'b0, 2'd0};
        nav_tbl[4] = '{1'b1, 1'b0, 2'd1};
        nav_tbl[5] = '{1'b0, 1'b1, 2'd0};
        nav_tbl[6] = '{1'b0, 1'b1, 2'd3};
        nav_tbl[7] = '{1'b1, 1'b1, 2'd3};
        nav_tbl[8] = '{1'b0, 1'b1, 2'd2};
        nav_tbl[9] = '{1'b1, 1'b0, 2'd3};
        nav_tbl[10] = '{1'b1, 1'b0, 2'd0};

        // reset state
        @(negedge clk);
        step();
        check("reset_outs", {15'd0, outs()}, {15'd0, pack(IDLE, IDLE, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0)});
        check("reset_rd", {30'd0, buf_rd_addr}, 32'd0);
        rst = 1'b0;
        step();
        check("idle_holds", {15'd0, outs()}, {15'd0, pack(IDLE, IDLE, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0)});

        // full run with random ignored inputs
        do_run(1'b0, 1'b1, 40);
        repeat (3) step();
        check("done_holds", {15'd0, outs()}, {15'd0, exp_q[40]});

        // display navigation table
        toggle = 1'b1;
        repeat (SYNC_LAT + 2) step();
        for (int i = 0; i < 11; i++) begin
            right = nav_tbl[i].r;
            left = nav_tbl[i].l;
            step();
            right = 1'b0;
            left = 1'b0;
            repeat (SYNC_LAT + 1) step();
            check($sformatf("nav%0d", i), {30'd0, buf_rd_addr}, {30'd0, nav_tbl[i].exp_rd});
        end

        // held right: latency then exactly one step
        right = 1'b1;
        for (int i = 0; i < SYNC_LAT; i++) begin
            step();
            check("right_latency", {30'd0, buf_rd_addr}, 32'd0);
        end
        step();
        check("right_step", {30'd0, buf_rd_addr}, 32'd1);
        repeat (9) step();
        check("right_held", {30'd0, buf_rd_addr}, 32'd1);
        right = 1'b0;
        repeat (SYNC_LAT + 2) step();

        // random navigation against a level-history model
        rd_m = 1;
        rq.delete();
        lq.delete();
        repeat (4) begin
            rq.push_back(1'b0);
            lq.push_back(1'b0);
        end
        for (int c = 0; c < 60; c++) begin
            right = 1'($urandom % 2);
            left = 1'($urandom % 2);
            rq.push_back(right);
            lq.push_back(left);
            n = rq.size();
            er = rq[n - 1 - SYNC_LAT] && !rq[n - 2 - SYNC_LAT];
            el = lq[n - 1 - SYNC_LAT] && !lq[n - 2 - SYNC_LAT];
            pr = er && !el;
            pl = el && !er;
            if (pr) rd_m = (rd_m + 1) % 4;
            else if (pl) rd_m = (rd_m + 3) % 4;
            step();
            check($sformatf("rand_nav%0d", c), {30'd0, buf_rd_addr}, 32'(rd_m));
        end
        right = 1'b0;
        left = 1'b0;
        repeat (SYNC_LAT + 2) step();

        // leave display: address kept, buttons ignored in DONE
        toggle = 1'b0;
        repeat (SYNC_LAT + 2) step();
        check("exit_display_rd", {29'd0, done, buf_rd_addr}, {29'd0, 1'b1, 2'(rd_m)});
        right = 1'b1;
        repeat (SYNC_LAT + 2) step();
        right = 1'b0;
        check("btn_ignored_done", {30'd0, buf_rd_addr}, 32'(rd_m));

        // reset back to idle, then abort during the write of pixel 1
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        do_run(1'b0, 1'b0, 19);
        #1 rst = 1'b1;
        #1 check("abort_outs", {13'd0, buf_rd_addr, outs()},
                 {13'd0, 2'd0, pack(IDLE, IDLE, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0)});
        step();
        rst = 1'b0;
        step();

        // rerun with start and toggle held high
        do_run(1'b1, 1'b1, 40);
        repeat (4) step();
        check("no_restart", {15'd0, outs()}, {15'd0, exp_q[40]});
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
